// File: rtl/sobel_pkg.sv
// Shared defaults and FSM encoding for the Sobel window controller.
// Imported by the controller top and its coordinate counter.
package sobel_pkg;

  localparam int IMAGE_WIDTH_DEF  = 64;
  localparam int IMAGE_HEIGHT_DEF = 64;
  localparam int PX_SIZE          = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_window_ctrl_px_coord_counter.sv
// Column/row pixel coordinate counter with wrap at COLS-1 / ROWS-1.
// Flags report the last column and last row of the current position.
module px_coord_counter #(
  parameter int COLS = 64,
  parameter int ROWS = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_en,
  output logic [$clog2(COLS)-1:0] o_col,
  output logic [$clog2(ROWS)-1:0] o_row,
  output logic                    o_col_last,
  output logic                    o_row_last
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_col_last = (r_col == CW'(COLS - 1));
  assign o_row_last = (r_row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (o_col_last) begin
        r_col <= '0;
        r_row <= o_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Control for a 3x3 Sobel window: line-buffer shift, zero padding,
// and centre coordinate / border tagging of each window result.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            input_data_valid,
  output logic                            shift_en,
  output logic                            pad_sel,
  output logic                            out_valid,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  out_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_row,
  output logic                            out_border,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            ovf
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int FW = $clog2(IMAGE_WIDTH + 1);

  state_t r_state;
  state_t w_state_nxt;

  logic          w_in_en;
  logic [CW-1:0] w_in_col;
  logic [RW-1:0] w_in_row;
  logic          w_in_col_last;
  logic          w_in_row_last;

  logic          w_emit;
  logic [CW-1:0] w_oc_col;
  logic [RW-1:0] w_oc_row;
  logic          w_oc_col_last;
  logic          w_oc_row_last;
  logic          w_border;

  logic [FW-1:0] r_flush_cnt;
  logic          w_flush_last;

  logic          r_out_valid;
  logic [CW-1:0] r_out_col;
  logic [RW-1:0] r_out_row;
  logic          r_out_border;
  logic          r_frame_done;
  logic          r_ovf;

  px_coord_counter #(
    .COLS (IMAGE_WIDTH),
    .ROWS (IMAGE_HEIGHT)
  ) u_in_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (w_in_en),
    .o_col      (w_in_col),
    .o_row      (w_in_row),
    .o_col_last (w_in_col_last),
    .o_row_last (w_in_row_last)
  );

  px_coord_counter #(
    .COLS (IMAGE_WIDTH),
    .ROWS (IMAGE_HEIGHT)
  ) u_out_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (w_emit),
    .o_col      (w_oc_col),
    .o_row      (w_oc_row),
    .o_col_last (w_oc_col_last),
    .o_row_last (w_oc_row_last)
  );

  assign w_flush_last = (r_flush_cnt == FW'(IMAGE_WIDTH));

  assign w_border = (w_oc_col == '0) || (w_oc_row == '0) ||
                    w_oc_col_last || w_oc_row_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift W lands on input coordinate (1,0): window holds a full centre next.
  always_comb begin
    w_state_nxt = r_state;
    shift_en    = 1'b0;
    pad_sel     = 1'b0;
    w_in_en     = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        shift_en = input_data_valid;
        w_in_en  = input_data_valid;
        if (input_data_valid) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        shift_en = input_data_valid;
        w_in_en  = input_data_valid;
        if (input_data_valid && (w_in_row == RW'(1)) &&
            (w_in_col == '0)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        shift_en = input_data_valid;
        w_in_en  = input_data_valid;
        w_emit   = input_data_valid;
        if (input_data_valid && w_in_col_last && w_in_row_last) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        shift_en = 1'b1;
        pad_sel  = 1'b1;
        w_emit   = 1'b1;
        if (w_flush_last) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flush_cnt <= '0;
    end else if (r_state == S_FLUSH) begin
      r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_out_border <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_out_border <= w_emit & w_border;
      r_frame_done <= w_emit & w_oc_col_last & w_oc_row_last;
      if (w_emit) begin
        r_out_col <= w_oc_col;
        r_out_row <= w_oc_row;
      end
      if ((r_state == S_FLUSH) && input_data_valid) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign out_border = r_out_border;
  assign frame_done = r_frame_done;
  assign ovf        = r_ovf;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: 64x64 instance for frame
// flow/reset/overflow, 4x4 instance for border tagging.
module tb_sobel_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_cyc = 0;
  always @(posedge clk) m_cyc++;

  // 64x64 instance
  logic       rstn64 = 1'b0;
  logic       vld64  = 1'b0;
  logic       se64, pad64, ov64, bd64, fd64, busy64, ovf64;
  logic [5:0] oc64;
  logic [5:0] or64;

  sobel_window_ctrl #(
    .IMAGE_WIDTH  (64),
    .IMAGE_HEIGHT (64)
  ) dut64 (
    .clk              (clk),
    .resetn           (rstn64),
    .input_data_valid (vld64),
    .shift_en         (se64),
    .pad_sel          (pad64),
    .out_valid        (ov64),
    .out_col          (oc64),
    .out_row          (or64),
    .out_border       (bd64),
    .frame_done       (fd64),
    .busy             (busy64),
    .ovf              (ovf64)
  );

  // 4x4 instance
  logic       rstn4 = 1'b0;
  logic       vld4  = 1'b0;
  logic       se4, pad4, ov4, bd4, fd4, busy4, ovf4;
  logic [1:0] oc4;
  logic [1:0] or4;

  sobel_window_ctrl #(
    .IMAGE_WIDTH  (4),
    .IMAGE_HEIGHT (4)
  ) dut4 (
    .clk              (clk),
    .resetn           (rstn4),
    .input_data_valid (vld4),
    .shift_en         (se4),
    .pad_sel          (pad4),
    .out_valid        (ov4),
    .out_col          (oc4),
    .out_row          (or4),
    .out_border       (bd4),
    .frame_done       (fd4),
    .busy             (busy4),
    .ovf              (ovf4)
  );

  // 64x64 observation: reference raster-order centre model
  int m_col = 0, m_row = 0;
  int m_vcount, m_fd, m_fd_col, m_fd_row, m_order_err, m_gap_err;
  int m_fd_err, m_pad_cnt, m_pad_run, m_pad_max, m_first_cyc;
  bit m_first_seen, m_prev_shift;
  bit m_exp_b;

  always @(negedge clk) begin
    if (!rstn64) begin
      m_col = 0;
      m_row = 0;
      m_prev_shift = 0;
      m_pad_run = 0;
    end else begin
      if (ov64) begin
        if (!m_prev_shift) m_gap_err++;
        if (!m_first_seen) begin
          m_first_seen = 1;
          m_first_cyc = m_cyc;
        end
        m_exp_b = (m_col == 0) || (m_row == 0) ||
                  (m_col == 63) || (m_row == 63);
        if (int'(oc64) != m_col || int'(or64) != m_row ||
            bd64 !== m_exp_b)
          m_order_err++;
        m_vcount++;
        if (fd64) begin
          m_fd++;
          m_fd_col = int'(oc64);
          m_fd_row = int'(or64);
        end
        if (m_col == 63) begin
          m_col = 0;
          m_row = (m_row == 63) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end else if (fd64) begin
        m_fd_err++;
      end
      if (pad64) begin
        m_pad_cnt++;
        m_pad_run++;
        if (m_pad_run > m_pad_max) m_pad_max = m_pad_run;
      end else begin
        m_pad_run = 0;
      end
      m_prev_shift = se64;
    end
  end

  // 4x4 observation
  int         n4 = 0, p4 = 0, f4 = 0;
  logic [1:0] c4 [16];
  logic [1:0] r4 [16];
  logic       b4 [16];

  always @(negedge clk) begin
    if (rstn4) begin
      if (ov4) begin
        if (n4 < 16) begin
          c4[n4] = oc4;
          r4[n4] = or4;
          b4[n4] = bd4;
        end
        n4++;
        if (fd4) f4++;
      end
      if (pad4) p4++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats;
    m_vcount = 0; m_fd = 0; m_fd_col = -1; m_fd_row = -1;
    m_order_err = 0; m_gap_err = 0; m_fd_err = 0;
    m_pad_cnt = 0; m_pad_max = 0; m_first_seen = 0; m_first_cyc = -1;
  endtask

  task automatic wait_idle64(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy64) begin
        ok = 1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({ov64, bd64, fd64, ovf64, busy64, pad64, se64} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000000",
               {ov64, bd64, fd64, ovf64, busy64, pad64, se64});
    end
    total++;
    if (oc64 !== 6'd0 || or64 !== 6'd0) begin
      bad++;
      $display("FAIL reset_coord got=(%0d,%0d) want=(0,0)", or64, oc64);
    end
    total++;
    if (busy4 !== 1'b0 || ov4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4 got busy=%b ov=%b want 0 0", busy4, ov4);
    end
    tick();
    rstn64 = 1'b1;
    rstn4  = 1'b1;
    tick();
  endtask

  task automatic test_continuous;
    bit ok;
    int start;
    clear_stats();
    tick();
    start = m_cyc;
    vld64 = 1'b1;
    repeat (4096) tick();
    vld64 = 1'b0;
    wait_idle64(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cont_timeout got busy want idle"); end
    total++;
    if (m_first_cyc != start + 66) begin
      bad++;
      $display("FAIL cont_first got=%0d want=%0d", m_first_cyc, start + 66);
    end
    total++;
    if (m_vcount != 4096) begin
      bad++; $display("FAIL cont_count got=%0d want=4096", m_vcount);
    end
    total++;
    if (m_order_err != 0 || m_gap_err != 0 || m_fd_err != 0) begin
      bad++;
      $display("FAIL cont_order got=%0d/%0d/%0d want=0/0/0",
               m_order_err, m_gap_err, m_fd_err);
    end
    total++;
    if (m_fd != 1 || m_fd_col != 63 || m_fd_row != 63) begin
      bad++;
      $display("FAIL cont_fd got n=%0d at (%0d,%0d) want 1 at (63,63)",
               m_fd, m_fd_row, m_fd_col);
    end
    total++;
    if (m_pad_cnt != 65 || m_pad_max != 65) begin
      bad++;
      $display("FAIL cont_pad got=%0d run=%0d want=65", m_pad_cnt, m_pad_max);
    end
    total++;
    if (ovf64 !== 1'b0) begin
      bad++; $display("FAIL cont_ovf got=%b want=0", ovf64);
    end
  endtask

  task automatic test_toggle;
    bit ok;
    clear_stats();
    for (int i = 0; i < 4096; i++) begin
      vld64 = 1'b1;
      tick();
      vld64 = 1'b0;
      tick();
    end
    wait_idle64(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tog_timeout got busy want idle"); end
    total++;
    if (m_vcount != 4096 || m_order_err != 0) begin
      bad++;
      $display("FAIL tog_outputs got=%0d err=%0d want=4096 err=0",
               m_vcount, m_order_err);
    end
    total++;
    if (m_gap_err != 0) begin
      bad++; $display("FAIL tog_gap got=%0d want=0", m_gap_err);
    end
    total++;
    if (m_pad_cnt != 65 || m_pad_max != 65) begin
      bad++;
      $display("FAIL tog_flush got=%0d run=%0d want=65", m_pad_cnt, m_pad_max);
    end
    total++;
    if (m_fd != 1 || m_fd_err != 0) begin
      bad++; $display("FAIL tog_fd got=%0d err=%0d want=1", m_fd, m_fd_err);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit found;
    clear_stats();
    tick();
    vld64 = 1'b1;
    repeat (4096) tick();
    vld64 = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (fd64) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL b2b_fd1 got none want pulse"); end
    tick();
    vld64 = 1'b1;
    #1;
    total++;
    if (se64 !== 1'b1 || busy64 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart got se=%b busy=%b want 1 0", se64, busy64);
    end
    repeat (4096) tick();
    vld64 = 1'b0;
    wait_idle64(ok);
    total++;
    if (!ok || m_vcount != 8192 || m_order_err != 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d err=%0d ok=%b want=8192 0 1",
               m_vcount, m_order_err, ok);
    end
    total++;
    if (m_fd != 2 || m_fd_err != 0) begin
      bad++; $display("FAIL b2b_fd got=%0d want=2", m_fd);
    end
    total++;
    if (ovf64 !== 1'b0 || m_pad_cnt != 130) begin
      bad++;
      $display("FAIL b2b_ovf got ovf=%b pad=%0d want 0 130", ovf64, m_pad_cnt);
    end
  endtask

  task automatic test_ovf;
    bit ok;
    clear_stats();
    tick();
    vld64 = 1'b1;
    repeat (4096) tick();
    repeat (3) tick();
    vld64 = 1'b0;
    total++;
    if (ovf64 !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%b want=1", ovf64);
    end
    wait_idle64(ok);
    repeat (20) tick();
    total++;
    if (ovf64 !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b want=1", ovf64);
    end
    total++;
    if (!ok || m_vcount != 4096 || m_pad_cnt != 65) begin
      bad++;
      $display("FAIL ovf_frame got=%0d pad=%0d want=4096 65",
               m_vcount, m_pad_cnt);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int start;
    clear_stats();
    tick();
    vld64 = 1'b1;
    repeat (2000) tick();
    total++;
    if (ov64 !== 1'b1 || busy64 !== 1'b1) begin
      bad++;
      $display("FAIL mrst_pre got ov=%b busy=%b want 1 1", ov64, busy64);
    end
    rstn64 = 1'b0;
    #1;
    total++;
    if ({ov64, bd64, fd64, ovf64, busy64} !== 5'b0) begin
      bad++;
      $display("FAIL mrst_flags got=%b want=00000",
               {ov64, bd64, fd64, ovf64, busy64});
    end
    total++;
    if (oc64 !== 6'd0 || or64 !== 6'd0) begin
      bad++;
      $display("FAIL mrst_coord got=(%0d,%0d) want=(0,0)", or64, oc64);
    end
    vld64 = 1'b0;
    repeat (2) tick();
    rstn64 = 1'b1;
    tick();
    clear_stats();
    tick();
    start = m_cyc;
    vld64 = 1'b1;
    repeat (4096) tick();
    vld64 = 1'b0;
    wait_idle64(ok);
    total++;
    if (!ok || m_vcount != 4096 || m_order_err != 0) begin
      bad++;
      $display("FAIL mrst_frame got=%0d err=%0d ok=%b want=4096 0 1",
               m_vcount, m_order_err, ok);
    end
    total++;
    if (m_first_cyc != start + 66 || m_fd != 1) begin
      bad++;
      $display("FAIL mrst_first got=%0d fd=%0d want=%0d fd=1",
               m_first_cyc, m_fd, start + 66);
    end
  endtask

  task automatic test_small;
    bit ok;
    bit exp_b;
    n4 = 0; p4 = 0; f4 = 0;
    tick();
    vld4 = 1'b1;
    repeat (16) tick();
    vld4 = 1'b0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy4) begin
        ok = 1;
        break;
      end
    end
    repeat (3) tick();
    total++;
    if (!ok || n4 != 16 || f4 != 1) begin
      bad++;
      $display("FAIL small_count got=%0d fd=%0d ok=%b want=16 1 1", n4, f4, ok);
    end
    total++;
    if (p4 != 5) begin
      bad++; $display("FAIL small_pad got=%0d want=5", p4);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b = !(i == 5 || i == 6 || i == 9 || i == 10);
      total++;
      if (b4[i] !== exp_b || int'(c4[i]) != i % 4 || int'(r4[i]) != i / 4) begin
        bad++;
        $display("FAIL small_ctr%0d got=(%0d,%0d) b=%b want=(%0d,%0d) b=%b",
                 i, r4[i], c4[i], b4[i], i / 4, i % 4, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_back_to_back();
    test_ovf();
    test_mid_reset();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter IMAGE_WIDTH, default 64, pixels per line (W); SHALL be >= 3.
REQ-002 Parameter IMAGE_HEIGHT, default 64, lines per frame (H); SHALL be >= 3.
REQ-003 clk  in  1  single clock; all logic SHALL run on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 input_data_valid  in  1  one input pixel present this cycle.
REQ-006 shift_en  out  1  advance line buffers and 3x3 window this cycle (combinational).
REQ-007 pad_sel  out  1  datapath SHALL shift zero instead of input_data (combinational).
REQ-008 out_valid  out  1  registered; window centre result valid.
REQ-009 out_col  out  clog2(W)  registered centre column for out_valid.
REQ-010 out_row  out  clog2(H)  registered centre row for out_valid.
REQ-011 out_border  out  1  registered; centre on row 0, row H-1, col 0 or col W-1; datapath SHALL output 0.
REQ-012 frame_done  out  1  registered one-cycle pulse with the last out_valid of a frame.
REQ-013 busy  out  1  state != IDLE.
REQ-014 ovf  out  1  sticky; input_data_valid seen during FLUSH.

Function
REQ-015 FSM states IDLE, FILL, RUN, FLUSH; shift k = k-th shift_en cycle since frame start, k from 0.
REQ-016 IDLE: shift_en = input_data_valid; a valid pixel is shift 0 and moves to FILL.
REQ-017 FILL: shift_en = input_data_valid; no out_valid; after shift W (W+1 shifts total) moves to RUN.
REQ-018 RUN: shift_en = input_data_valid; each shift k produces out_valid next cycle for centre index k-(W+1).
REQ-019 Input coordinate counter (col wraps W-1->0, then row++) SHALL advance on every non-pad shift; shift at (H-1, W-1) moves to FLUSH.
REQ-020 FLUSH: shift_en=1 and pad_sel=1 every cycle for exactly W+1 cycles, each producing one out_valid; input_data_valid ignored.
REQ-021 After the last FLUSH shift, state SHALL return to IDLE; frame_done SHALL be high in the same cycle as out_valid for centre (H-1, W-1).
REQ-022 Output counter (out_col wraps W-1->0, out_row++; out_row wraps H-1->0) SHALL advance after each out_valid; exactly W*H out_valid per frame.
REQ-023 Latency: out_valid 1 cycle after its causing shift; no valid when shift_en=0 (gaps in input_data_valid stall, never drop).
REQ-024 input_data_valid in the cycle after frame_done SHALL be shift 0 of the next frame (back-to-back frames allowed).
REQ-025 ovf SHALL set on input_data_valid in FLUSH and clear only on reset.
REQ-026 Counters SHALL be unsigned, width clog2 of their range; no arithmetic overflow beyond wrap points.

Reset
REQ-027 resetn low SHALL immediately force state IDLE, all counters 0, out_valid/out_border/frame_done/ovf 0, out_col/out_row 0.
REQ-028 Reset mid-frame SHALL abandon the frame; first valid pixel after release is shift 0.

Structure
REQ-029 Shared package sobel_pkg SHALL hold IMAGE_WIDTH/IMAGE_HEIGHT/PX_SIZE defaults and FSM state encoding.
REQ-030 One sub-module px_coord_counter (col/row with wrap, enable, wrap flags) SHALL be instantiated twice: input side and output side.

Verification
REQ-031 W=H=64, 4096 continuous pixels -> first out_valid at cycle after shift 65 with (0,0) border=1; 4096 out_valid total; frame_done once, with (63,63).
REQ-032 W=H=64, input_data_valid toggling 1/0 -> same 4096 outputs in same order, none during gaps; FLUSH still 65 consecutive cycles.
REQ-033 W=H=4: centre (1,1),(1,2),(2,1),(2,2) border=0, other 12 border=1; pad_sel high exactly 5 cycles.
REQ-034 Two back-to-back 64x64 frames -> 8192 out_valid, two frame_done pulses, ovf=0; pixel during FLUSH -> ovf=1 and sticky.
REQ-035 resetn low at shift 2000 -> outputs 0, busy=0 same cycle; next frame -> full 4096 outputs from (0,0).
